// File: rtl/mux_select_pipe.sv
// mux_select_pipe: registered NUM_IN-way select stage with a valid/ready
// handshake and a 2-entry skid buffer. An out-of-range select produces
// zero data, and the error flag travels with the item. A saturating
// counter tracks these select errors.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no item held, out_valid=0
// ST_MAIN  | main register holds the output item
// ST_FULL  | main and skid both hold items, in_ready=0
module mux_select_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             drain;
  logic             load_new_main;
  logic             load_skid_main;
  logic             load_new_skid;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_data;
  assign out_err   = main_err;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  // Channel select; any select with no matching channel yields zero data and sets the error flag.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == k[SEL_W-1:0]) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  // Next state and register load enables for the E/M/F occupancy states.
  always_comb begin
    state_next     = state;
    load_new_main  = 1'b0;
    load_skid_main = 1'b0;
    load_new_skid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next    = ST_MAIN;
          load_new_main = 1'b1;
        end
      end
      ST_MAIN: begin
        if (drain && accept) begin
          load_new_main = 1'b1;
        end else if (drain) begin
          state_next = ST_EMPTY;
        end else if (accept) begin
          state_next    = ST_FULL;
          load_new_skid = 1'b1;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_next     = ST_MAIN;
          load_skid_main = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // State register; in_ready is registered from the next state so out_ready has no comb path to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_FULL);
    end
  end

  // Main and skid data registers; main holds its value while the stage is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_new_main) begin
        main_data <= sel_data;
        main_err  <= sel_err;
      end else if (load_skid_main) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_new_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

  // Saturating count of accepted items whose select was out of range.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && sel_err && !(&err_count)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
